hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It tracks the destination register and remaining result latency (Tnew) of the instructions in E, M and W, and the source registers of E and M. From that state it drives the stall/bubble signal and the select inputs of every forwarding multiplexer (D, E and M stages, including the M-stage store-data forward). It also runs the multiply/divide busy counter that serialises HI/LO instructions.

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: tracks E/M/W destinations and
// Tnew, produces stall and every forwarding select, and times the mult/div unit.
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] md_kind_D,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic       md_busy
);

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_kind_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    md_kind_e   md;
  } e_entry_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } m_entry_t;

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  e_entry_t         e_q, e_d;
  m_entry_t         m_q, m_d;
  logic [4:0]       w_a3_q, w_a3_d;
  logic [CNT_W-1:0] busy_q, busy_d;

  logic data_stall, md_stall;

  // A source must wait when a producer in E or M still needs more cycles than the reader can spare.
  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input e_entry_t e, input m_entry_t m);
    return (r != 5'd0) && (tuse != 2'd3) &&
           (((e.a3 == r) && (e.tnew > tuse)) || ((m.a3 == r) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] r, input e_entry_t e,
                                       input m_entry_t m, input logic [4:0] w_a3);
    if (r == 5'd0)                             return 2'd0;
    else if ((e.a3 == r) && (e.tnew == 2'd0))  return 2'd1;
    else if ((m.a3 == r) && (m.tnew == 2'd0))  return 2'd2;
    else if (w_a3 == r)                        return 2'd3;
    else                                       return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] r, input m_entry_t m,
                                       input logic [4:0] w_a3);
    if (r == 5'd0)                             return 2'd0;
    else if ((m.a3 == r) && (m.tnew == 2'd0))  return 2'd1;
    else if (w_a3 == r)                        return 2'd2;
    else                                       return 2'd0;
  endfunction

  always_comb begin
    data_stall = src_stall(rs_D, tuse_rs_D, e_q, m_q) || src_stall(rt_D, tuse_rt_D, e_q, m_q);
    md_stall   = (md_kind_D != 2'd0) &&
                 ((busy_q != '0) || (e_q.md == MD_MULT) || (e_q.md == MD_DIV));
    stall      = data_stall || md_stall;
    fwd_rs_D   = sel_d(rs_D, e_q, m_q, w_a3_q);
    fwd_rt_D   = sel_d(rt_D, e_q, m_q, w_a3_q);
    fwd_rs_E   = sel_e(e_q.rs, m_q, w_a3_q);
    fwd_rt_E   = sel_e(e_q.rt, m_q, w_a3_q);
    fwd_rt_M   = (m_q.rt != 5'd0) && (w_a3_q == m_q.rt);
    md_busy    = (busy_q != '0);
  end

  // NOTE: every next-state signal gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    e_d    = '0;
    m_d    = '0;
    w_a3_d = '0;
    if (!flush) begin
      m_d.rt   = e_q.rt;
      m_d.a3   = e_q.a3;
      m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      w_a3_d   = m_q.a3;
      if (!stall) begin
        e_d.rs   = rs_D;
        e_d.rt   = rt_D;
        e_d.a3   = a3_D;
        e_d.tnew = tnew_D;
        e_d.md   = md_kind_e'(md_kind_D);
      end
    end
  end

  // A flush cancels an MDU start still in E but lets an operation already launched run out.
  always_comb begin
    busy_d = (busy_q == '0) ? '0 : busy_q - CNT_W'(1);
    if (!flush && (e_q.md == MD_MULT))     busy_d = CNT_W'(MULT_CYCLES);
    else if (!flush && (e_q.md == MD_DIV)) busy_d = CNT_W'(DIV_CYCLES);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_a3_q <= '0;
      busy_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_a3_q <= w_a3_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives the D inputs, queues the expected
// output vector, and compares it mid-cycle against the DUT.
`timescale 1ns/1ps

module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D, md_kind_D;
  logic       flush;
  logic       stall, fwd_rt_M, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int tests = 0;
  int fails = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .tuse_rs_D (tuse_rs_D),
    .tuse_rt_D (tuse_rt_D),
    .a3_D      (a3_D),
    .tnew_D    (tnew_D),
    .md_kind_D (md_kind_D),
    .flush     (flush),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E),
    .fwd_rt_M  (fwd_rt_M),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy}
  function automatic logic [10:0] ex(input logic st, input logic [1:0] frsd, input logic [1:0] frtd,
                                     input logic [1:0] frse, input logic [1:0] frte,
                                     input logic frtm, input logic bsy);
    return {st, frsd, frtd, frse, frte, frtm, bsy};
  endfunction

  task automatic compare();
    logic [10:0] obs;
    logic [10:0] e;
    string       t;
    obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (stall,frsD,frtD,frsE,frtE,frtM,busy)", t, obs, e);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] urs, input logic [1:0] urt, input logic [4:0] a3,
                      input logic [1:0] tn, input logic [1:0] md, input logic fl,
                      input logic [10:0] e);
    @(negedge clk);
    rs_D = rs; rt_D = rt; tuse_rs_D = urs; tuse_rt_D = urt;
    a3_D = a3; tnew_D = tn; md_kind_D = md; flush = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1;
    rs_D = '0; rt_D = '0; tuse_rs_D = '0; tuse_rt_D = '0;
    a3_D = '0; tnew_D = '0; md_kind_D = '0; flush = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    tag_q.push_back("reset_state");
    #3;
    compare();
    @(negedge clk);
    reset = 1'b0;

    // lw $8 then add $9,$8,$8: one stall, then W forwarding into E
    step("lw_issue",     29, 8, 1, 3, 8, 2, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("lw_use_stall",  8, 8, 1, 1, 9, 1, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
    step("lw_use_go",     8, 8, 1, 1, 9, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("lw_use_fwd_w",  0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 2, 2, 0, 0));

    // add $8 then beq $8,$0: one stall, then M forwarding into D
    step("add_issue",     1, 2, 1, 1, 8, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("beq_stall",     8, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
    step("beq_fwd_m",     8, 0, 0, 0, 0, 0, 0, 0, ex(0, 2, 0, 0, 0, 0, 0));

    // add $8 then sw $8: no stall, rt forwarded in E from M, then in M from W
    step("add2_issue",    3, 4, 1, 1, 8, 1, 0, 0, ex(0, 0, 0, 2, 0, 0, 0));
    step("sw_no_stall",  29, 8, 1, 2, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("sw_fwd_rt_e",   0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 0));
    step("sw_fwd_rt_m",   0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 0));

    // mult then mflo: 1 stall cycle for mult in E plus 5 busy cycles
    step("mult_issue",    4, 5, 1, 1, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("mflo_mult_e",   0, 0, 3, 3, 10, 1, 3, 0, ex(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      step($sformatf("mflo_busy_%0d", i), 0, 0, 3, 3, 10, 1, 3, 0, ex(1, 0, 0, 0, 0, 0, 1));
    step("mflo_released", 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

    // asynchronous reset in the middle of an MDU operation
    step("mult2_issue",   4, 5, 1, 1, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("mult2_in_m",    0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("mflo2_busy",    0, 0, 3, 3, 10, 1, 3, 0, ex(1, 0, 0, 0, 0, 0, 1));
    #1;
    reset = 1'b1;
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    tag_q.push_back("async_reset_mid_busy");
    #1;
    compare();
    #1;
    reset = 1'b0;

    // register 0 never stalls or forwards
    step("lui_r0",        0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("add_reads_r0",  0, 0, 1, 1, 9, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("lw_r0",        29, 0, 1, 3, 0, 2, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("beq_r0_no_stall", 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

    // flush with a load in E removes the hazard
    step("lw3_issue",    29, 8, 1, 3, 8, 2, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("flush_w_stall", 8, 8, 1, 1, 9, 1, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
    step("after_flush",   8, 8, 1, 1, 9, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

    // flush cancels an MDU start still in E
    step("mult3_issue",   4, 5, 1, 1, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("flush_mult",    0, 0, 3, 3, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
    step("mult_cancelled", 0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

    // div busy lasts 10 cycles and survives a flush
    step("div_issue",     4, 5, 1, 1, 0, 0, 2, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("div_in_m",      0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step($sformatf("div_busy_%0d", i), 0, 0, 3, 3, 0, 0, 0, (i == 3), ex(0, 0, 0, 0, 0, 0, 1));
    step("div_done",      0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));

    // forwarding priority: nearest stage wins when E, M and W all write $8
    step("lui8_a",        0, 0, 3, 3, 8, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("lui8_b",        0, 0, 3, 3, 8, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("lui8_c",        0, 0, 3, 3, 8, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    step("prio_d_e",      8, 8, 0, 0, 0, 0, 0, 0, ex(0, 1, 1, 0, 0, 0, 0));
    step("prio_e_m",      0, 0, 3, 3, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
